uart_rx_buf: RTL and testbench

UART_RX_BUF -- requirements
Module: uart_rx_buf

---
 rtl/uart_rx_buf_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/uart_rx_buf.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_buf.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_buf_pkg.sv
// Shared definitions for the buffered UART receiver: FSM state encodings and default timing.
// Defining UART_RX_PARITY_EN adds the PARITY state and the even-parity helper.
package uart_rx_buf_pkg;

  localparam int DEF_CLK_DIV     = 13;
  localparam int DEF_SAMPLE_RATE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

`ifdef UART_RX_PARITY_EN
  // Even parity over up to 9 data bits; callers zero-extend narrower frames.
  function automatic logic even_parity(input logic [8:0] bits);
    return ^bits;
  endfunction
`endif

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count; DEPTH must be a power of 2.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [AW:0]       level_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LEVEL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; empty-gating of dout hides stale contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q] <= din;
  end

  assign dout  = empty ? '0 : mem[rd_q];
  assign level = level_q;

endmodule

// File: rtl/uart_rx_buf.sv
// Oversampling UART receiver feeding a FWFT FIFO, with frame-error pulse and sticky overrun.
// Define UART_RX_PARITY_EN to receive one even-parity bit between data and stop.
module uart_rx_buf
  import uart_rx_buf_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int SAMPLE_RATE = DEF_SAMPLE_RATE,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   rx_i,
  output logic [DATA_W-1:0]      tx_o,
  output logic                   tx_o_v,
  input  logic                   tx_o_rdy,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   frame_err_o,
  output logic                   overrun_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SR_W  = $clog2(SAMPLE_RATE);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [SR_W-1:0]  SR_MAX   = SR_W'(SAMPLE_RATE - 1);
  localparam logic [SR_W-1:0]  HALF_MAX = SR_W'(SAMPLE_RATE / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  // Line synchroniser and falling-edge detect
  logic [1:0] sync_q;
  logic       line_prev_q;
  logic       line;
  logic       fall;

  assign line = sync_q[1];
  assign fall = line_prev_q & ~line;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync_q      <= 2'b11;
      line_prev_q <= 1'b1;
    end else begin
      sync_q      <= {sync_q[0], rx_i};
      line_prev_q <= line;
    end
  end

  // Free-running oversample tick
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_MAX);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) div_q <= '0;
    else         div_q <= tick ? '0 : div_q + 1'b1;
  end

  // Receive FSM
  rx_state_e         state_q, state_d;
  logic [SR_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              push;
  logic              err_d;
  logic              frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    err_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d   = ST_START;
          smp_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (smp_cnt_q == HALF_MAX) begin
            smp_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = line ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end else begin
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (smp_cnt_q == SR_MAX) begin
            smp_cnt_d = '0;
            shreg_d   = {line, shreg_q[DATA_W-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (smp_cnt_q == SR_MAX) begin
            smp_cnt_d = '0;
            par_bad_d = (line != even_parity(9'(shreg_q)));
            state_d   = ST_STOP;
          end else begin
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (smp_cnt_q == SR_MAX) begin
            smp_cnt_d = '0;
            state_d   = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            push      = line & ~par_bad_q;
            err_d     = ~line | par_bad_q;
`else
            push      = line;
            err_d     = ~line;
`endif
          end else begin
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      smp_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
`endif
    end
  end

  // Output FIFO and overrun tracking
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic overrun_q;

  assign tx_o_v = ~fifo_empty;
  assign pop    = tx_o_v & tx_o_rdy;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (push),
    .din    (shreg_q),
    .pop    (pop),
    .dout   (tx_o),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) overrun_q <= 1'b0;
    else         overrun_q <= overrun_q | (push & fifo_full & ~pop);
  end

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Self-checking bench for uart_rx_buf: table-driven frames plus hand-written corner sequences.
// Popped bytes are compared against a queue of expected frames filled as frames are sent.
`timescale 1ns/1ps
module tb_uart_rx_buf;

  localparam int CLK_DIV = 2;
  localparam int SR      = 16;
  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int BIT_CLK = CLK_DIV * SR;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          rx   = 1'b1;
  logic          rdy  = 1'b0;
  logic [DW-1:0] tx;
  logic          tx_v;
  logic [2:0]    level;
  logic          ferr;
  logic          ovr;

  uart_rx_buf #(
    .CLK_DIV     (CLK_DIV),
    .SAMPLE_RATE (SR),
    .DATA_W      (DW),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .rx_i        (rx),
    .tx_o        (tx),
    .tx_o_v      (tx_v),
    .tx_o_rdy    (rdy),
    .level_o     (level),
    .frame_err_o (ferr),
    .overrun_o   (ovr)
  );

  always #5 clk = ~clk;

  int            n_vec      = 0;
  int            n_err      = 0;
  int            err_pulses = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_head;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted pop must match the oldest expected frame.
  always @(negedge clk) begin
    if (rstn) begin
      if (ferr) err_pulses++;
      if (tx_v && rdy) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pop: got 0x%0h, no frame expected", tx);
        end else begin
          exp_head = exp_q.pop_front();
          check("pop_data", tx, exp_head);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one full frame; rise = clock index within the stop bit where tx_v first reads high.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_flip,
                            input bit end_level, output int rise);
    rise = -1;
    rx = 1'b0;
    clocks(BIT_CLK);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      clocks(BIT_CLK);
    end
    if (PAR_EN) begin
      rx = (^d) ^ par_flip;
      clocks(BIT_CLK);
    end
    rx = stop;
    for (int c = 1; c <= BIT_CLK; c++) begin
      clocks(1);
      if (rise < 0 && tx_v) rise = c;
    end
    rx = end_level;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         par_flip;
    bit         ok;
  } vec_t;

  vec_t vecs[8];
  int   rise;
  int   e0;

  initial begin
    vecs[0] = '{8'h00, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h07, 1'b1, 1'b1, !PAR_EN};
    vecs[6] = '{8'h07, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{8'hC3, 1'b0, 1'b0, 1'b0};

    // Reset state
    clocks(4);
    check("rst_tx",      tx,    0);
    check("rst_tx_v",    tx_v,  0);
    check("rst_level",   level, 0);
    check("rst_ferr",    ferr,  0);
    check("rst_overrun", ovr,   0);
    rstn = 1'b1;
    clocks(4);

    // Single good frame, consumer stalled
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, rise);
    check("a5_valid_rise_in_window", (rise >= 14 && rise <= 24), 1);
    check("a5_tx",    tx,         8'hA5);
    check("a5_tx_v",  tx_v,       1);
    check("a5_level", level,      1);
    check("a5_no_err", err_pulses, 0);
    rdy = 1'b1;
    clocks(4);
    rdy = 1'b0;
    check("a5_drained", level, 0);

    // Table of frames: good, bad stop, and (with parity) bad parity
    foreach (vecs[k]) begin
      e0 = err_pulses;
      if (vecs[k].ok) exp_q.push_back(vecs[k].data);
      send_frame(vecs[k].data, vecs[k].stop, vecs[k].par_flip, 1'b1, rise);
      clocks(8);
      check("vec_err_pulses", err_pulses - e0, {31'd0, !vecs[k].ok});
      check("vec_level",      level,           {31'd0, vecs[k].ok});
      check("vec_tx_v",       tx_v,            {31'd0, vecs[k].ok});
      if (vecs[k].ok) check("vec_tx", tx, vecs[k].data);
      rdy = 1'b1;
      clocks(4);
      rdy = 1'b0;
      check("vec_drained", level, 0);
    end

    // Bad stop with line held low: no new frame until line goes high
    e0 = err_pulses;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, rise);
    clocks(3 * BIT_CLK);
    check("hold_low_err",   err_pulses - e0, 1);
    check("hold_low_level", level,           0);
    rx = 1'b1;
    clocks(BIT_CLK);
    check("hold_low_no_extra_err", err_pulses - e0, 1);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, 1'b0, 1'b1, rise);
    clocks(8);
    check("after_hold_tx", tx, 8'h42);
    rdy = 1'b1;
    clocks(4);
    rdy = 1'b0;

    // Start-bit glitch, then a frame received with ready held high on an empty FIFO
    e0 = err_pulses;
    rx = 1'b0;
    clocks(5);
    rx = 1'b1;
    clocks(2 * BIT_CLK);
    check("glitch_level", level,           0);
    check("glitch_tx_v",  tx_v,            0);
    check("glitch_err",   err_pulses - e0, 0);
    rdy = 1'b1;
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1, 1'b0, 1'b1, rise);
    clocks(8);
    rdy = 1'b0;
    check("glitch_next_popped", exp_q.size(), 0);
    check("glitch_next_level",  level,        0);

    // Overrun: five frames into a four-deep FIFO
    e0 = err_pulses;
    for (int i = 1; i <= 5; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1'b0, 1'b1, rise);
      clocks(4);
      if (i == DEPTH) begin
        check("full_level",      level, 4);
        check("full_no_overrun", ovr,   0);
      end
    end
    check("ovr_level", level,           4);
    check("ovr_flag",  ovr,             1);
    check("ovr_head",  tx,              8'h01);
    check("ovr_err",   err_pulses - e0, 0);
    rdy = 1'b1;
    clocks(10);
    rdy = 1'b0;
    check("ovr_drained_q",  exp_q.size(), 0);
    check("ovr_drained",    level,        0);
    check("ovr_sticky",     ovr,          1);

    // Reset in the middle of a frame, with a byte sitting in the FIFO
    send_frame(8'h11, 1'b1, 1'b0, 1'b1, rise);
    clocks(4);
    check("pre_rst_level", level, 1);
    rx = 1'b0;
    clocks(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx = 8'h55 >> i;
      clocks(BIT_CLK);
    end
    rx = 1'b1;
    clocks(BIT_CLK / 2);
    rstn = 1'b0;
    clocks(2);
    check("midrst_tx",      tx,    0);
    check("midrst_tx_v",    tx_v,  0);
    check("midrst_level",   level, 0);
    check("midrst_ferr",    ferr,  0);
    check("midrst_overrun", ovr,   0);
    e0 = err_pulses;
    rstn = 1'b1;
    rx = 1'b1;
    clocks(2 * BIT_CLK);
    check("midrst_no_push", level,           0);
    check("midrst_no_err",  err_pulses - e0, 0);
    exp_q.push_back(8'h66);
    send_frame(8'h66, 1'b1, 1'b0, 1'b1, rise);
    clocks(4);
    check("post_rst_tx",    tx,    8'h66);
    check("post_rst_level", level, 1);
    rdy = 1'b1;

    for (int c = 0; c < 200 && exp_q.size() != 0; c++) clocks(1);
    check("final_queue_empty", exp_q.size(), 0);
    clocks(2);
    check("final_level", level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
